// File: rtl/trng_bus_master_if.sv
// trng_bus_master_if
// Groups the host byte link (rx/tx syn-ack handshakes) and the TRNG internal
// register bus into one bundle. The master modport is the command initiator;
// the slave modport is the far side (host link endpoints plus register responder).
interface trng_bus_master_if;
    // host link, receive direction
    logic        rx_syn;
    logic [7:0]  rx_data;
    logic        rx_ack;
    // host link, transmit direction
    logic        tx_syn;
    logic [7:0]  tx_data;
    logic        tx_ack;
    // internal register bus
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        error;

    modport master (
        input  rx_syn, rx_data, tx_ack, read_data, error,
        output rx_ack, tx_syn, tx_data, cs, we, address, write_data
    );

    modport slave (
        output rx_syn, rx_data, tx_ack, read_data, error,
        input  rx_ack, tx_syn, tx_data, cs, we, address, write_data
    );
endinterface

// File: rtl/trng_bus_master.sv
// trng_bus_master
// Byte-stream command initiator for the TRNG internal register bus. Framed
// read/write commands arrive over a syn/ack byte link, each is executed as a
// single-cycle bus transaction, and a framed response is streamed back.
//
// Optional feature: define TRNG_BUS_MASTER_ERR_RESP_EN to turn a bus error
// seen in the transaction cycle into a bus-error response frame. Without it,
// error is ignored and the OK response is always returned.
module trng_bus_master (
    input  logic              clk,
    input  logic              reset_n,
    trng_bus_master_if.master bus
);

    // framing constants
    localparam logic [7:0] SOC           = 8'h55;
    localparam logic [7:0] EOC           = 8'hAA;
    localparam logic [7:0] SOR           = 8'hAA;
    localparam logic [7:0] EOR           = 8'h55;
    localparam logic [7:0] CMD_READ      = 8'h10;
    localparam logic [7:0] CMD_WRITE     = 8'h11;
    localparam logic [7:0] RESP_READ_OK  = 8'h7F;
    localparam logic [7:0] RESP_WRITE_OK = 8'h7E;
    localparam logic [7:0] RESP_UNKNOWN  = 8'hFE;
    localparam logic [7:0] RESP_BUS_ERR  = 8'hFD;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_CMD,
        S_RX_ADDR,
        S_RX_DATA,
        S_RX_EOC,
        S_RX_FLUSH,
        S_BUS,
        S_TX_LOAD,
        S_TX_SEND,
        S_TX_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // receive side
    logic        r_rx_ack;
    logic [7:0]  r_rx_byte;
    logic        w_receiving;
    logic        w_rx_take;
    logic        w_byte_vld;

    // command being assembled
    logic        r_is_write;
    logic [7:0]  r_cmd;
    logic [7:0]  r_addr_lat;
    logic [31:0] r_wdata_sh;
    logic [1:0]  r_byte_cnt;

    // bus-facing registers
    logic [7:0]  r_address;
    logic [31:0] r_write_data;
    logic        w_bus_err;

    // response buffer
    logic [7:0]  r_tx_buf [0:7];
    logic [2:0]  r_tx_idx;
    logic [2:0]  r_tx_last;

    // decoded outputs
    logic        w_cs;
    logic        w_we;
    logic        w_tx_syn;
    logic [7:0]  w_tx_data;

`ifdef TRNG_BUS_MASTER_ERR_RESP_EN
    assign w_bus_err = bus.error;
`else
    // error is deliberately ignored in this build
    logic w_unused_error;
    assign w_unused_error = bus.error;
    assign w_bus_err      = 1'b0;
`endif

    // Bytes are only accepted in the frame-parsing states; during the bus
    // cycle and the whole response the host byte stays pending.
    assign w_receiving = (r_state == S_IDLE)    || (r_state == S_RX_CMD)  ||
                         (r_state == S_RX_ADDR) || (r_state == S_RX_DATA) ||
                         (r_state == S_RX_EOC)  || (r_state == S_RX_FLUSH);

    // rx_syn is ignored while rx_ack is high, which limits the link to one
    // byte every two cycles and gives the source time to drop or advance.
    assign w_rx_take  = w_receiving && bus.rx_syn && !r_rx_ack;

    // The registered byte is decoded during its rx_ack cycle.
    assign w_byte_vld = r_rx_ack;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: frame parsing, bus cycle, response streaming
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_byte_vld && (r_rx_byte == SOC)) begin
                    w_state_nxt = S_RX_CMD;
                end
            end
            S_RX_CMD: begin
                if (w_byte_vld) begin
                    if ((r_rx_byte == CMD_READ) || (r_rx_byte == CMD_WRITE)) begin
                        w_state_nxt = S_RX_ADDR;
                    end else begin
                        w_state_nxt = S_RX_FLUSH;
                    end
                end
            end
            S_RX_ADDR: begin
                if (w_byte_vld) begin
                    w_state_nxt = r_is_write ? S_RX_DATA : S_RX_EOC;
                end
            end
            S_RX_DATA: begin
                if (w_byte_vld && (r_byte_cnt == 2'd3)) begin
                    w_state_nxt = S_RX_EOC;
                end
            end
            S_RX_EOC: begin
                // a wrong terminator silently drops the whole frame
                if (w_byte_vld) begin
                    w_state_nxt = (r_rx_byte == EOC) ? S_BUS : S_IDLE;
                end
            end
            S_RX_FLUSH: begin
                if (w_byte_vld && (r_rx_byte == EOC)) begin
                    w_state_nxt = S_TX_LOAD;
                end
            end
            S_BUS:     w_state_nxt = S_TX_SEND;
            S_TX_LOAD: w_state_nxt = S_TX_SEND;
            S_TX_SEND: begin
                if (bus.tx_ack) begin
                    w_state_nxt = (r_tx_idx == r_tx_last) ? S_IDLE : S_TX_WAIT;
                end
            end
            S_TX_WAIT: w_state_nxt = S_TX_SEND;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: bus strobe in the BUS state, current byte in TX_SEND
    always_comb begin
        w_cs      = 1'b0;
        w_we      = 1'b0;
        w_tx_syn  = 1'b0;
        w_tx_data = 8'h00;
        unique case (r_state)
            S_BUS: begin
                w_cs = 1'b1;
                w_we = r_is_write;
            end
            S_TX_SEND: begin
                w_tx_syn  = 1'b1;
                w_tx_data = r_tx_buf[r_tx_idx];
            end
            default: begin
                w_cs      = 1'b0;
            end
        endcase
    end

    // Receive handshake: one-cycle rx_ack after each accepted byte
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_ack <= 1'b0;
        end else begin
            r_rx_ack <= w_rx_take;
        end
    end

    // Capture the accepted host byte
    always_ff @(posedge clk) begin
        if (w_rx_take) begin
            r_rx_byte <= bus.rx_data;
        end
    end

    // Command-type flag and write-data byte counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_is_write <= 1'b0;
            r_byte_cnt <= 2'd0;
        end else if (w_byte_vld) begin
            unique case (r_state)
                S_RX_CMD:  r_is_write <= (r_rx_byte == CMD_WRITE);
                S_RX_ADDR: r_byte_cnt <= 2'd0;
                S_RX_DATA: r_byte_cnt <= r_byte_cnt + 2'd1;
                default:   r_byte_cnt <= r_byte_cnt;
            endcase
        end
    end

    // Latch command code, address and the MSB-first write payload
    always_ff @(posedge clk) begin
        if (w_byte_vld) begin
            unique case (r_state)
                S_RX_CMD:  r_cmd      <= r_rx_byte;
                S_RX_ADDR: r_addr_lat <= r_rx_byte;
                S_RX_DATA: r_wdata_sh <= {r_wdata_sh[23:0], r_rx_byte};
                default:   r_cmd      <= r_cmd;
            endcase
        end
    end

    // Bus address/data move only on entry to the bus cycle; reads leave the
    // previous write data on the bus untouched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_address    <= 8'h00;
            r_write_data <= 32'h0000_0000;
        end else if (w_state_nxt == S_BUS) begin
            r_address <= r_addr_lat;
            if (r_is_write) begin
                r_write_data <= r_wdata_sh;
            end
        end
    end

    // Build the response frame from the bus result or from the unknown command
    always_ff @(posedge clk) begin
        if (r_state == S_BUS) begin
            r_tx_buf[0] <= SOR;
            r_tx_buf[2] <= r_address;
            if (w_bus_err) begin
                r_tx_buf[1] <= RESP_BUS_ERR;
                r_tx_buf[3] <= EOR;
            end else if (r_is_write) begin
                r_tx_buf[1] <= RESP_WRITE_OK;
                r_tx_buf[3] <= EOR;
            end else begin
                r_tx_buf[1] <= RESP_READ_OK;
                r_tx_buf[3] <= bus.read_data[31:24];
                r_tx_buf[4] <= bus.read_data[23:16];
                r_tx_buf[5] <= bus.read_data[15:8];
                r_tx_buf[6] <= bus.read_data[7:0];
                r_tx_buf[7] <= EOR;
            end
        end else if (r_state == S_TX_LOAD) begin
            r_tx_buf[0] <= SOR;
            r_tx_buf[1] <= RESP_UNKNOWN;
            r_tx_buf[2] <= r_cmd;
            r_tx_buf[3] <= EOR;
        end
    end

    // Response length and read pointer; pointer advances on each tx_ack
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_idx  <= 3'd0;
            r_tx_last <= 3'd0;
        end else begin
            unique case (r_state)
                S_BUS: begin
                    r_tx_idx  <= 3'd0;
                    r_tx_last <= (!w_bus_err && !r_is_write) ? 3'd7 : 3'd3;
                end
                S_TX_LOAD: begin
                    r_tx_idx  <= 3'd0;
                    r_tx_last <= 3'd3;
                end
                S_TX_SEND: begin
                    if (bus.tx_ack) begin
                        r_tx_idx <= r_tx_idx + 3'd1;
                    end
                end
                default: begin
                    r_tx_idx <= r_tx_idx;
                end
            endcase
        end
    end

    assign bus.rx_ack     = r_rx_ack;
    assign bus.tx_syn     = w_tx_syn;
    assign bus.tx_data    = w_tx_data;
    assign bus.cs         = w_cs;
    assign bus.we         = w_we;
    assign bus.address    = r_address;
    assign bus.write_data = r_write_data;

endmodule

// File: tb/tb_trng_bus_master.sv
// tb_trng_bus_master
// Table of command frames with their expected bus cycle and response bytes,
// a response scoreboard fed when frames are driven, and hand sequences for
// tx stall/backpressure, back-to-back frames and reset mid-response.
// Honours TRNG_BUS_MASTER_ERR_RESP_EN for the bus-error expectation.
module tb_trng_bus_master;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic tx_ack_r = 1'b0;
    logic sink_stall = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cs_cnt  = 0;

    logic [7:0] exp_q [$];

    trng_bus_master_if bif ();

    assign bif.tx_ack = tx_ack_r;

    trng_bus_master dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [63:0] frm;
        int          frm_len;
        logic [31:0] rdata;
        logic        err;
        logic        exp_bus;
        logic        exp_we;
        logic [7:0]  exp_addr;
        logic [31:0] exp_wdata;
        logic [63:0] rsp;
        int          rsp_len;
    } vec_t;

    vec_t vecs [8];

    function automatic vec_t mkv(input logic [63:0] frm, input int frm_len,
                                 input logic [31:0] rdata, input logic err,
                                 input logic exp_bus, input logic exp_we,
                                 input logic [7:0] exp_addr, input logic [31:0] exp_wdata,
                                 input logic [63:0] rsp, input int rsp_len);
        vec_t v;
        v.frm = frm; v.frm_len = frm_len; v.rdata = rdata; v.err = err;
        v.exp_bus = exp_bus; v.exp_we = exp_we; v.exp_addr = exp_addr;
        v.exp_wdata = exp_wdata; v.rsp = rsp; v.rsp_len = rsp_len;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // count cs pulses
    always @(negedge clk) begin
        if (bif.cs) cs_cnt++;
    end

    // tx sink: compares each presented byte with the scoreboard, then acks it
    always @(negedge clk) begin
        if (tx_ack_r) begin
            tx_ack_r = 1'b0;
            chk("tx_gap", bif.tx_syn, 1'b0);
        end else if (bif.tx_syn && !sink_stall) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte 0x%02h, required no byte", bif.tx_data);
            end else begin
                chk("tx_byte", bif.tx_data, exp_q.pop_front());
            end
            tx_ack_r = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        bif.rx_syn  = 1'b1;
        bif.rx_data = b;
        do begin
            @(negedge clk);
            k++;
        end while (!bif.rx_ack && k < 100);
        chk("rx_ack_seen", bif.rx_ack, 1'b1);
        bif.rx_syn = 1'b0;
    endtask

    task automatic push_rsp(input logic [63:0] rsp, input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(rsp[63-8*i -: 8]);
    endtask

    task automatic send_frame(input logic [63:0] frm, input int len);
        for (int i = 0; i < len; i++) send_byte(frm[63-8*i -: 8]);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || bif.tx_syn || tx_ack_r) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_drain_done"}, (k < 400), 1'b1);
    endtask

    task automatic wait_tx(input string name);
        int k = 0;
        while (!bif.tx_syn && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_tx_started"}, bif.tx_syn, 1'b1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cs0;
        string nm;
        nm = $sformatf("vec%0d", idx);
        bif.read_data = v.rdata;
        bif.error     = v.err;
        push_rsp(v.rsp, v.rsp_len);
        cs0 = cs_cnt;
        send_frame(v.frm, v.frm_len);
        if (v.exp_bus) begin
            @(negedge clk);
            chk({nm, "_cs"}, bif.cs, 1'b1);
            chk({nm, "_we"}, bif.we, v.exp_we);
            chk({nm, "_address"}, bif.address, v.exp_addr);
            chk({nm, "_write_data"}, bif.write_data, v.exp_wdata);
            @(negedge clk);
            chk({nm, "_tx_latency"}, bif.tx_syn, 1'b1);
        end
        drain(nm);
        repeat (3) @(negedge clk);
        chk({nm, "_cs_pulses"}, cs_cnt - cs0, v.exp_bus ? 1 : 0);
    endtask

    initial begin
        logic [7:0] held;
        logic       hold_ok;
        logic       ack_seen;
        logic       got;
        int         tx_cnt;

        vecs[0] = mkv(64'h551000AA_00000000, 4, 32'h73686132, 1'b0, 1'b1, 1'b0, 8'h00,
                      32'h00000000, 64'hAA7F0073_68613255, 8);
        vecs[1] = mkv(64'h551110DE_ADBEEFAA, 8, 32'h00000000, 1'b0, 1'b1, 1'b1, 8'h10,
                      32'hDEADBEEF, 64'hAA7E1055_00000000, 4);
`ifdef TRNG_BUS_MASTER_ERR_RESP_EN
        vecs[2] = mkv(64'h551020AA_00000000, 4, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'h20,
                      32'hDEADBEEF, 64'hAAFD2055_00000000, 4);
`else
        vecs[2] = mkv(64'h551020AA_00000000, 4, 32'h00000000, 1'b1, 1'b1, 1'b0, 8'h20,
                      32'hDEADBEEF, 64'hAA7F2000_00000055, 8);
`endif
        vecs[3] = mkv(64'h554201AA_00000000, 4, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h00,
                      32'h00000000, 64'hAAFE4255_00000000, 4);
        vecs[4] = mkv(64'h55100033_00000000, 4, 32'h00000000, 1'b0, 1'b0, 1'b0, 8'h00,
                      32'h00000000, 64'h0, 0);
        vecs[5] = mkv(64'h551005AA_00000000, 4, 32'h12345678, 1'b0, 1'b1, 1'b0, 8'h05,
                      32'hDEADBEEF, 64'hAA7F0512_34567855, 8);
        vecs[6] = mkv(64'h5511FF00_000001AA, 8, 32'h00000000, 1'b0, 1'b1, 1'b1, 8'hFF,
                      32'h00000001, 64'hAA7EFF55_00000000, 4);
        vecs[7] = mkv(64'h00551007_AA000000, 5, 32'h89ABCDEF, 1'b0, 1'b1, 1'b0, 8'h07,
                      32'h00000001, 64'hAA7F0789_ABCDEF55, 8);

        bif.rx_syn    = 1'b0;
        bif.rx_data   = 8'h00;
        bif.read_data = 32'h0;
        bif.error     = 1'b0;

        // reset state
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rx_ack", bif.rx_ack, 1'b0);
        chk("rst_tx_syn", bif.tx_syn, 1'b0);
        chk("rst_tx_data", bif.tx_data, 8'h00);
        chk("rst_cs", bif.cs, 1'b0);
        chk("rst_we", bif.we, 1'b0);
        chk("rst_address", bif.address, 8'h00);
        chk("rst_write_data", bif.write_data, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // tx stall: byte held, pending rx byte not consumed, then back-to-back frame
        sink_stall    = 1'b1;
        bif.read_data = 32'hCAFEF00D;
        bif.error     = 1'b0;
        push_rsp(64'hAA7F00CA_FEF00D55, 8);
        send_frame(64'h551000AA_00000000, 4);
        wait_tx("stall");
        chk("stall_first_byte", bif.tx_data, 8'hAA);
        held        = bif.tx_data;
        bif.rx_syn  = 1'b1;
        bif.rx_data = 8'h55;
        hold_ok     = 1'b1;
        ack_seen    = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!bif.tx_syn || bif.tx_data !== held) hold_ok = 1'b0;
            if (bif.rx_ack) ack_seen = 1'b1;
        end
        chk("stall_tx_held", hold_ok, 1'b1);
        chk("stall_rx_ack_low", ack_seen, 1'b0);
        sink_stall = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bif.rx_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk("b2b_soc_taken", got, 1'b1);
        chk("b2b_soc_after_response", exp_q.size(), 0);
        bif.rx_syn    = 1'b0;
        bif.read_data = 32'h0BADF00D;
        push_rsp(64'hAA7F050B_ADF00D55, 8);
        send_frame(64'h1005AA00_00000000, 3);
        drain("b2b");

        // reset in the middle of a response
        sink_stall    = 1'b1;
        bif.read_data = 32'h11223344;
        push_rsp(64'hAA7F3C11_22334455, 8);
        send_frame(64'h55103CAA_00000000, 4);
        wait_tx("midrst");
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_rx_ack", bif.rx_ack, 1'b0);
        chk("midrst_tx_syn", bif.tx_syn, 1'b0);
        chk("midrst_tx_data", bif.tx_data, 8'h00);
        chk("midrst_cs", bif.cs, 1'b0);
        chk("midrst_we", bif.we, 1'b0);
        chk("midrst_address", bif.address, 8'h00);
        chk("midrst_write_data", bif.write_data, 32'h0);
        reset_n = 1'b1;
        exp_q.delete();
        sink_stall = 1'b0;
        tx_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (bif.tx_syn) tx_cnt++;
        end
        chk("midrst_no_tx_after", tx_cnt, 0);

        // recovery after reset
        run_vec(vecs[0], 8);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trng_bus_master.md
# trng_bus_master

Byte-stream command initiator that drives the TRNG internal register bus (cs/we/address/write_data in, read_data/error back). It receives framed read/write commands from a host byte link, such as the debug UART receiver. It executes each command as a single-cycle bus transaction against the debug/control and core register responders, then returns a framed response byte stream to the link transmitter. Host-side tooling uses it to read core name/version registers and to write control registers.

## Interface
- No parameters. Fixed framing constants: SOC 0x55, EOC 0xAA, SOR 0xAA, EOR 0x55, CMD_READ 0x10, CMD_WRITE 0x11, RESP_READ_OK 0x7F, RESP_WRITE_OK 0x7E, RESP_UNKNOWN 0xFE, RESP_BUS_ERR 0xFD.
- clk  in  1  clock.
- reset_n  in  1  reset, synchronous, active-low.
- rx_syn  in  1  host byte valid; held until rx_ack.
- rx_data  in  8  host byte.
- rx_ack  out  1  one-cycle byte-consumed pulse.
- tx_syn  out  1  response byte valid; held until tx_ack.
- tx_data  out  8  response byte, stable while tx_syn=1.
- tx_ack  in  1  response byte taken.
- cs  out  1  bus select, one-cycle pulse.
- we  out  1  bus write enable, valid with cs.
- address  out  8  bus address.
- write_data  out  32  bus write data.
- read_data  in  32  bus read data (combinational from responder).
- error  in  1  bus error (combinational from responder).

## Operation
- Command frames (host to block):
  - Read: SOC, 0x10, addr, EOC.
  - Write: SOC, 0x11, addr, d[31:24], d[23:16], d[15:8], d[7:0], EOC.
- FSM states: IDLE, RX_CMD, RX_ADDR, RX_DATA (byte counter 0..3), RX_EOC, RX_FLUSH, BUS, TX_LOAD, TX_SEND, TX_WAIT.
- State behaviour:
  - IDLE: non-SOC bytes are consumed and dropped. SOC moves to RX_CMD.
  - RX_CMD: 0x10/0x11 move to RX_ADDR. Any other code is latched and the FSM moves to RX_FLUSH.
  - RX_FLUSH: discards bytes until EOC, then responds with SOR, 0xFE, cmd, EOR.
  - RX_ADDR: latches the address. Read goes to RX_EOC; write goes to RX_DATA.
  - RX_DATA: shifts 4 bytes MSB first into write_data, then goes to RX_EOC.
  - RX_EOC: EOC moves to BUS. Any other byte discards the frame, sends no response, and returns to IDLE.
  - BUS: cs=1 for exactly one cycle, we=1 for writes. read_data and error are captured on that edge.
- Response frames (8-byte buffer with length counter):
  - read OK: SOR, 0x7F, addr, rd[31:24], rd[23:16], rd[15:8], rd[7:0], EOR (8 bytes).
  - write OK: SOR, 0x7E, addr, EOR (4 bytes).
  - bus error (see Configuration): SOR, 0xFD, addr, EOR.
- Receive backpressure: while in BUS/TX_*, rx_ack stays 0 and rx bytes remain pending.
- After the last response byte is acked, the FSM returns to IDLE.

## Timing
- Reset values: rx_ack=0, tx_syn=0, tx_data=0x00, cs=0, we=0, address=0x00, write_data=0, FSM=IDLE, counters=0.
- Reset mid-operation discards any partial command and any in-flight response, with no further bytes emitted.
- RX handshake:
  - When rx_syn=1 and rx_ack=0 in a receiving state, the block registers rx_data and asserts rx_ack the next cycle for one cycle.
  - rx_syn is ignored during the rx_ack cycle.
  - The source must drop rx_syn or present the next byte after that cycle.
  - Maximum rate is one byte per 2 cycles.
- EOC byte accepted (rx_ack cycle) -> cs high the next cycle.
- cs cycle -> tx_syn high with the first byte the next cycle.
- TX handshake:
  - tx_syn and tx_data hold until tx_ack is sampled 1.
  - tx_syn is then 0 for exactly one cycle before the next byte.
  - tx_ack while tx_syn=0 is ignored.
- cs, we, address and write_data all change only in the BUS cycle or on reset. address and write_data stay at their last values otherwise.
- Back-to-back frames: a SOC pending during TX_SEND is consumed only after return to IDLE.

## Configuration
- TRNG_BUS_MASTER_ERR_RESP_EN defined:
  - error=1 in the BUS cycle selects the bus-error response (SOR, 0xFD, addr, EOR) in place of the OK response.
  - For reads, the data bytes are not sent.
- Not defined:
  - error is ignored, and the OK response is always sent.
  - Read data bytes are whatever read_data was (0x00000000 from a conforming responder on error).

## Test plan
- Read of addr 0x00 with responder returning 0x73686132 -> one cs pulse (we=0, address=0x00), then tx bytes AA 7F 00 73 68 61 32 55.
- Write of 0xDEADBEEF to 0x10 -> cs=1, we=1, address=0x10, write_data=0xDEADBEEF for one cycle, then tx bytes AA 7E 10 55.
- Read of 0x20 where the responder asserts error -> with macro: AA FD 20 55. Without macro: AA 7F 20 00 00 00 00 55.
- Frame 55 42 01 AA -> no cs pulse, response AA FE 42 55. Frame 55 10 00 33 -> no cs pulse, no response, and the next valid frame works.
- Hold tx_ack low for 20 cycles mid-response -> tx_syn/tx_data held stable, rx_ack stays 0 despite a pending rx byte. Assert reset_n=0 mid-response -> all outputs at reset values next cycle, and no further tx bytes.
